// File: rtl/ebuf_pkg.sv
// Shared helpers for the elastic buffer family.
package ebuf_pkg;

    // Bits needed to hold a beat count of 0..depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/elastic_buffer_flushable.sv
// Valid/ready elastic buffer with a circular store, occupancy reporting and a
// synchronous flush; Bypass=1 turns it into wires.
module elastic_buffer_flushable
    import ebuf_pkg::*;
#(
    parameter int   WIDTH            = 1,
    parameter int   DEPTH            = 2,
    parameter int   AlmostFullThresh = DEPTH - 1,
    parameter logic Bypass           = 1'b0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [WIDTH-1:0]              data_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [WIDTH-1:0]              data_o,
    output logic [cnt_width(DEPTH)-1:0]   usage_o,
    output logic                          almost_full_o,
    output logic                          drop_o
);

    localparam int CW = cnt_width(DEPTH);

    if (DEPTH < 2) begin : g_chk_depth
        $error("elastic_buffer_flushable: DEPTH must be >= 2");
    end
    if (AlmostFullThresh < 1 || AlmostFullThresh > DEPTH) begin : g_chk_thresh
        $error("elastic_buffer_flushable: AlmostFullThresh must be in 1..DEPTH");
    end

    if (Bypass) begin : g_bypass
        assign valid_o       = valid_i & ~flush_i;
        assign ready_o       = ready_i;
        assign data_o        = data_i;
        assign usage_o       = '0;
        assign almost_full_o = 1'b0;
        assign drop_o        = flush_i & valid_i;
    end else begin : g_store
        localparam int            PW     = $clog2(DEPTH);
        localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
        localparam logic [CW-1:0] AF_C    = CW'(AlmostFullThresh);
        localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
        logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
        logic [CW-1:0]    count_q, count_d;
        logic             push, pop;

        assign ready_o       = (count_q < DEPTH_C);
        assign valid_o       = (count_q != '0);
        assign data_o        = mem_q[rd_ptr_q];
        assign usage_o       = count_q;
        assign almost_full_o = (count_q >= AF_C);
        assign drop_o        = flush_i & valid_i & ready_o;

        assign push = valid_i & ready_o & ~flush_i;
        assign pop  = valid_o & ready_i & ~flush_i;

        always_comb begin
            rd_ptr_d = rd_ptr_q;
            wr_ptr_d = wr_ptr_q;
            count_d  = count_q;
            if (flush_i) begin
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                count_d  = '0;
            end else begin
                if (push) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PW'(1);
                case ({push, pop})
                    2'b10:   count_d = count_q + CW'(1);
                    2'b01:   count_d = count_q - CW'(1);
                    default: count_d = count_q;
                endcase
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                rd_ptr_q <= rd_ptr_d;
                wr_ptr_q <= wr_ptr_d;
                count_q  <= count_d;
            end
        end

        // Entries are only ever written by a push; flush and pop leave them intact.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            end else if (push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule

// File: tb/tb_elastic_buffer_flushable.sv
// Self-checking bench: fixed vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_elastic_buffer_flushable;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush, valid_in, ready_in;
    logic [7:0] data_in;
    logic       ready_out, valid_out, af_out, drop_out;
    logic [7:0] data_out;
    logic [2:0] usage_out;

    logic       b_flush, b_valid_in, b_ready_in;
    logic [7:0] b_data_in;
    logic       b_ready_out, b_valid_out, b_af_out, b_drop_out;
    logic [7:0] b_data_out;
    logic [2:0] b_usage_out;

    always #5 clk = ~clk;

    elastic_buffer_flushable #(.WIDTH(8), .DEPTH(4), .AlmostFullThresh(3), .Bypass(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_in), .ready_o(ready_out),
        .data_i(data_in), .valid_o(valid_out), .ready_i(ready_in), .data_o(data_out),
        .usage_o(usage_out), .almost_full_o(af_out), .drop_o(drop_out)
    );

    elastic_buffer_flushable #(.WIDTH(8), .DEPTH(4), .AlmostFullThresh(3), .Bypass(1'b1)) dut_byp (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush), .valid_i(b_valid_in), .ready_o(b_ready_out),
        .data_i(b_data_in), .valid_o(b_valid_out), .ready_i(b_ready_in), .data_o(b_data_out),
        .usage_o(b_usage_out), .almost_full_o(b_af_out), .drop_o(b_drop_out)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] mq[$];
    logic       last_drop;
    bit         seen_aa;

    typedef struct {
        logic       v; logic [7:0] d; logic r; logic f;
        logic       ev; logic [7:0] ed; logic [2:0] eu; logic er; logic eaf; logic edrop;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [7:0] d, logic r, logic f, logic ev,
                                logic [7:0] ed, logic [2:0] eu, logic er, logic eaf, logic edrop);
        vec_t x;
        x.v = v; x.d = d; x.r = r; x.f = f; x.ev = ev; x.ed = ed;
        x.eu = eu; x.er = er; x.eaf = eaf; x.edrop = edrop;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a negedge; drives one cycle, checks against the model after the next edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic f);
        bit do_push, do_pop, full;
        valid_in = v; data_in = d; ready_in = r; flush = f;
        #1;
        full = (mq.size() >= 4);
        last_drop = drop_out;
        chk("drop", drop_out, f & v & !full);
        do_push = v & !full & !f;
        do_pop  = (mq.size() != 0) & r & !f;
        @(posedge clk);
        if (f) mq.delete();
        else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(d);
        end
        @(negedge clk);
        chk("valid", valid_out, mq.size() != 0);
        chk("ready", ready_out, mq.size() < 4);
        chk("usage", usage_out, mq.size());
        chk("almost_full", af_out, mq.size() >= 3);
        if (mq.size() != 0) chk("data", data_out, mq[0]);
        if (valid_out && data_out == 8'hAA) seen_aa = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 0; valid_in = 0; ready_in = 0; data_in = 0;
        b_flush = 0; b_valid_in = 0; b_ready_in = 0; b_data_in = 0;
        seen_aa = 0;

        // fill/drain, full-with-pop, flush-with-drop
        tbl.push_back(mk(1, 8'h11, 0, 0, 1, 8'h11, 1, 1, 0, 0));
        tbl.push_back(mk(1, 8'h22, 0, 0, 1, 8'h11, 2, 1, 0, 0));
        tbl.push_back(mk(1, 8'h33, 0, 0, 1, 8'h11, 3, 1, 1, 0));
        tbl.push_back(mk(1, 8'h44, 0, 0, 1, 8'h11, 4, 0, 1, 0));
        tbl.push_back(mk(1, 8'h55, 0, 0, 1, 8'h11, 4, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'h22, 3, 1, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'h33, 2, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'h44, 1, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(1, 8'h11, 0, 0, 1, 8'h11, 1, 1, 0, 0));
        tbl.push_back(mk(1, 8'h22, 0, 0, 1, 8'h11, 2, 1, 0, 0));
        tbl.push_back(mk(1, 8'h33, 0, 0, 1, 8'h11, 3, 1, 1, 0));
        tbl.push_back(mk(1, 8'h44, 0, 0, 1, 8'h11, 4, 0, 1, 0));
        tbl.push_back(mk(1, 8'h55, 1, 0, 1, 8'h22, 3, 1, 1, 0));
        tbl.push_back(mk(1, 8'hAA, 0, 1, 0, 8'h00, 0, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(1, 8'h66, 0, 0, 1, 8'h66, 1, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0, 0));

        @(negedge clk);
        chk("rst_valid", valid_out, 0);
        chk("rst_ready", ready_out, 1);
        chk("rst_data", data_out, 0);
        chk("rst_usage", usage_out, 0);
        chk("rst_af", af_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f);
            chk($sformatf("tbl%0d_valid", i), valid_out, tbl[i].ev);
            chk($sformatf("tbl%0d_usage", i), usage_out, tbl[i].eu);
            chk($sformatf("tbl%0d_ready", i), ready_out, tbl[i].er);
            chk($sformatf("tbl%0d_af", i), af_out, tbl[i].eaf);
            chk($sformatf("tbl%0d_drop", i), last_drop, tbl[i].edrop);
            if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), data_out, tbl[i].ed);
        end

        // streaming at full throughput
        for (int i = 0; i < 20; i++) begin
            cycle(1, 8'(i), 1, 0);
            chk("stream_usage", usage_out, 1);
            chk("stream_data", data_out, 8'(i));
        end
        cycle(0, 0, 1, 0);

        // randomized traffic with occasional flush
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 8'hA9)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        chk("aa_never_out", seen_aa, 0);

        // pointer wrap then reset mid-transfer
        cycle(0, 0, 0, 1);
        cycle(1, 8'hC1, 0, 0);
        cycle(1, 8'hC2, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 8'(8'hC3 + i), 1, 0);
        cycle(0, 0, 1, 0);
        chk("wrap_data", data_out, 8'hC6);
        valid_in = 1; data_in = 8'hEE; ready_in = 1;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", valid_out, 0);
        chk("midrst_ready", ready_out, 1);
        chk("midrst_data", data_out, 0);
        chk("midrst_usage", usage_out, 0);
        chk("midrst_af", af_out, 0);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 1, 0);
        chk("post_rst_empty", valid_out, 0);
        cycle(1, 8'h77, 0, 0);
        chk("post_rst_push", data_out, 8'h77);

        // bypass mode
        b_valid_in = 1; b_data_in = 8'h5A; b_ready_in = 0; b_flush = 0;
        #1;
        chk("byp_valid", b_valid_out, 1);
        chk("byp_data", b_data_out, 8'h5A);
        chk("byp_ready", b_ready_out, 0);
        chk("byp_usage", b_usage_out, 0);
        chk("byp_af", b_af_out, 0);
        chk("byp_drop", b_drop_out, 0);
        b_ready_in = 1; b_flush = 1;
        #1;
        chk("byp_ready_hi", b_ready_out, 1);
        chk("byp_flush_valid", b_valid_out, 0);
        chk("byp_flush_drop", b_drop_out, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
